// File: rtl/memory_responder_if.sv
// memory_responder_if: initiator bus plus byte-stream output channel of memory_responder
interface memory_responder_if;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        we;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  modport master (output address, data_in, we, out_ready, input data_out, out_data, out_valid);
  modport slave (input address, data_in, we, out_ready, output data_out, out_data, out_valid);
endinterface

// File: rtl/memory_responder.sv
// memory_responder: word RAM with one-cycle registered read; MEMORY_RESPONDER_MMIO_EN adds TXDATA/STATUS byte FIFO
module memory_responder #(
  parameter int MEM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             resetn,
  memory_responder_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [31:0] TXDATA = 32'h8000_0000;
  localparam logic [31:0] STATUS = 32'h8000_0004;
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] rd_mmio;
  logic        ram_hit;
  assign ram_hit = bus.address[31:AW+2] == '0;
  // RAM has no reset so it maps onto block memory; writes are still blocked while in reset
  always_ff @(posedge clk)
    if (!resetn && bus.we && ram_hit) mem[bus.address[AW+1:2]] <= bus.data_in;
  always_ff @(posedge clk or posedge resetn)
    if (resetn) bus.data_out <= '0;
    else bus.data_out <= ram_hit ? mem[bus.address[AW+1:2]] : rd_mmio;
`ifdef MEMORY_RESPONDER_MMIO_EN
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          overflow, full, empty, tx_wr, st_wr, push, pop;
  assign full  = count == (PW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign tx_wr = bus.we && bus.address == TXDATA;
  assign st_wr = bus.we && bus.address == STATUS;
  assign pop   = !empty && bus.out_ready;
  assign push  = tx_wr && (!full || pop);
  assign rd_mmio = bus.address == STATUS ? {19'b0, 5'(count), 5'b0, overflow, empty, full} : '0;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : fifo[rd_ptr];
  always_ff @(posedge clk)
    if (!resetn && push) fifo[wr_ptr] <= bus.data_in[7:0];
  // a dropped TXDATA write (tx_wr without push) sets overflow even when STATUS is cleared the same cycle
  always_ff @(posedge clk or posedge resetn)
    if (resetn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      rd_ptr   <= rd_ptr + PW'(pop);
      wr_ptr   <= wr_ptr + PW'(push);
      count    <= count + (PW+1)'(push) - (PW+1)'(pop);
      overflow <= (tx_wr && !push) || (overflow && !st_wr);
    end
`else
  logic unused;
  assign unused        = ^{bus.out_ready, bus.address[1:0], 32'(FIFO_DEPTH)};
  assign rd_mmio       = '0;
  assign bus.out_valid = 1'b0;
  assign bus.out_data  = '0;
`endif
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed vector table, reset sequence and randomized run against a queue-based model
module tb_memory_responder;
  localparam int MW = 1024;
  localparam int FD = 4;
  localparam logic [31:0] TX = 32'h8000_0000;
  localparam logic [31:0] ST = 32'h8000_0004;
`ifdef MEMORY_RESPONDER_MMIO_EN
  localparam bit M = 1'b1;
`else
  localparam bit M = 1'b0;
`endif
  logic clk = 1'b0;
  logic resetn = 1'b1;
  memory_responder_if bus();
  memory_responder #(.MEM_WORDS(MW), .FIFO_DEPTH(FD)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] ram_m [int];
  byte unsigned q[$];
  bit ovf = 1'b0;
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    bit          w;
    bit          r;
    bit          cd;
    logic [31:0] dout;
    bit          v;
    logic [7:0]  od;
  } vec_t;
  vec_t tv[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic model(input logic [31:0] a, input logic [31:0] d, input bit w, input bit r,
                       output logic [31:0] edout, output bit known);
    bit ram, pop, full, tx, sw;
    int idx;
    ram = a < MW * 4;
    idx = int'(a >> 2);
    if (ram) begin
      known = ram_m.exists(idx);
      edout = known ? ram_m[idx] : 32'h0;
    end else begin
      known = 1'b1;
      edout = (M && a == ST) ? {19'b0, 5'(q.size()), 5'b0, ovf, q.size() == 0, q.size() == FD} : 32'h0;
    end
    if (w && ram) ram_m[idx] = d;
    if (M) begin
      pop  = q.size() > 0 && r;
      full = q.size() == FD;
      tx   = w && a == TX;
      sw   = w && a == ST;
      if (pop) void'(q.pop_front());
      if (tx && (!full || pop)) q.push_back(d[7:0]);
      ovf = (tx && full && !pop) || (ovf && !sw);
    end
  endtask
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input bit w, input bit r,
                     output logic [31:0] edout, output bit known);
    bus.address = a;
    bus.data_in = d;
    bus.we = w;
    bus.out_ready = r;
    model(a, d, w, r, edout, known);
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(logic [31:0] a, logic [31:0] d, bit w, bit r, bit cd,
                              logic [31:0] dout, bit v, logic [7:0] od);
    vec_t x;
    x.a = a; x.d = d; x.w = w; x.r = r; x.cd = cd; x.dout = dout; x.v = v; x.od = od;
    return x;
  endfunction
  initial begin
    logic [31:0] ed, a;
    bit kn, w, r;
    int sel;
    bus.address = '0;
    bus.data_in = '0;
    bus.we = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst data_out", bus.data_out, 0);
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst out_data", 32'(bus.out_data), 0);
    resetn = 1'b0;
    tv.push_back(mk(32'h10, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk(32'h10, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0));
    tv.push_back(mk(32'h13, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0));
    tv.push_back(mk(32'h20, 1, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk(32'h20, 2, 1, 0, 1, 1, 0, 0));
    tv.push_back(mk(32'h20, 0, 0, 0, 1, 2, 0, 0));
    tv.push_back(mk(MW * 4, 32'h55, 1, 0, 1, 0, 0, 0));
    tv.push_back(mk(MW * 4, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(32'h4000_0000, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(TX, 32'h41, 1, 0, 1, 0, M, M ? 8'h41 : 8'h0));
    tv.push_back(mk(TX, 32'h42, 1, 0, 1, 0, M, M ? 8'h41 : 8'h0));
    tv.push_back(mk(TX, 32'h43, 1, 0, 1, 0, M, M ? 8'h41 : 8'h0));
    tv.push_back(mk(ST, 0, 0, 0, 1, M ? 32'h300 : 0, M, M ? 8'h41 : 8'h0));
    tv.push_back(mk(TX, 0, 0, 1, 1, 0, M, M ? 8'h42 : 8'h0));
    tv.push_back(mk(TX, 0, 0, 1, 1, 0, M, M ? 8'h43 : 8'h0));
    tv.push_back(mk(ST, 0, 0, 1, 1, M ? 32'h100 : 0, 0, 0));
    tv.push_back(mk(ST, 0, 0, 1, 1, M ? 32'h2 : 0, 0, 0));
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(TX, 32'h50 + i, 1, 0, 1, 0, M, M ? 8'h50 : 8'h0));
    tv.push_back(mk(ST, 0, 0, 0, 1, M ? 32'h405 : 0, M, M ? 8'h50 : 8'h0));
    tv.push_back(mk(ST, 0, 1, 0, 1, M ? 32'h405 : 0, M, M ? 8'h50 : 8'h0));
    tv.push_back(mk(ST, 0, 0, 0, 1, M ? 32'h401 : 0, M, M ? 8'h50 : 8'h0));
    tv.push_back(mk(TX, 32'h60, 1, 1, 1, 0, M, M ? 8'h51 : 8'h0));
    tv.push_back(mk(ST, 0, 0, 0, 1, M ? 32'h401 : 0, M, M ? 8'h51 : 8'h0));
    foreach (tv[i]) begin
      cyc(tv[i].a, tv[i].d, tv[i].w, tv[i].r, ed, kn);
      if (tv[i].cd) chk($sformatf("vec%0d data_out", i), bus.data_out, tv[i].dout);
      chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(tv[i].v));
      chk($sformatf("vec%0d out_data", i), 32'(bus.out_data), 32'(tv[i].od));
    end
    cyc(32'h10, 0, 0, 1, ed, kn);
    cyc(32'h10, 0, 0, 1, ed, kn);
    chk("drain data_out", bus.data_out, 32'hDEADBEEF);
    chk("drain out_valid", 32'(bus.out_valid), 32'(M));
    chk("drain out_data", 32'(bus.out_data), M ? 32'h53 : 32'h0);
    #2 resetn = 1'b1;
    #1;
    chk("async rst data_out", bus.data_out, 0);
    chk("async rst out_valid", 32'(bus.out_valid), 0);
    chk("async rst out_data", 32'(bus.out_data), 0);
    bus.address = 32'h10; bus.data_in = 0; bus.we = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.address = TX; bus.data_in = 32'h77;
    @(posedge clk);
    #3 resetn = 1'b0;
    q.delete();
    ovf = 1'b0;
    cyc(32'h10, 0, 0, 0, ed, kn);
    chk("post rst ram", bus.data_out, 32'hDEADBEEF);
    chk("post rst out_valid", 32'(bus.out_valid), 0);
    cyc(ST, 0, 0, 0, ed, kn);
    chk("post rst status", bus.data_out, M ? 32'h2 : 32'h0);
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5) a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      else if (sel < 7) a = TX;
      else if (sel == 7) a = ST;
      else if (sel == 8) a = MW * 4 + ($urandom_range(0, 255) << 2);
      else a = 32'h4000_0000 | ($urandom & 32'h3FFF_FFFF);
      w = $urandom_range(0, 2) != 0;
      r = (i < 300) ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
      cyc(a, $urandom, w, r, ed, kn);
      if (kn) chk($sformatf("rnd%0d data_out", i), bus.data_out, ed);
      chk($sformatf("rnd%0d out_valid", i), 32'(bus.out_valid), 32'(q.size() > 0));
      chk($sformatf("rnd%0d out_data", i), 32'(bus.out_data), q.size() > 0 ? 32'(q[0]) : 32'h0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
